// File: rtl/floor_disp_pkg.sv
// Shared definitions for the elevator floor indicator.
//   - Active-low seven-segment codes, bit order {g,f,e,d,c,b,a}.
//   - FSM state encoding.
//   - floor_label(): floor index -> {mezzanine flag, digit}.
//   - digit_seg(): digit 1..9 -> segment code. Any other value gives blank.
package floor_disp_pkg;

  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_U     = 7'b1000001;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVING  = 2'd1,
    ARRIVED = 2'd2
  } state_t;

  typedef struct packed {
    logic       mezz;
    logic [3:0] digit;
  } label_t;

  // Whole floors use odd indices above 0. Each even nonzero index is the
  // mezzanine ("nA") sitting above the whole floor with the same digit.
  function automatic label_t floor_label(input logic [3:0] index);
    label_t     lbl;
    logic [4:0] sum;
    sum       = {1'b0, index} + 5'd1;
    lbl.digit = sum[4:1] + 4'd1;
    lbl.mezz  = (index[0] == 1'b0) && (index != 4'd0);
    return lbl;
  endfunction

  function automatic logic [6:0] digit_seg(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Blink phase generator. The phase bit toggles once every BLINK_DIV cycles.
//   clk    : clock; all state changes on its rising edge.
//   reset  : asynchronous, active-high. Sets count = 0 and phase = 1.
//   clear  : synchronous. Holds count = 0 and phase = 1.
//   phase  : current blink phase. 1 = digits visible.
//   wrap   : count is at its last value. phase toggles on the next edge
//            unless clear is high.
module blink_timer #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic phase,
  output logic wrap
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt;

  assign wrap = (cnt == LAST);

  // Counter wraps at LAST and flips the phase at that moment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (clear) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (wrap) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CW'(1);
      phase <= phase;
    end
  end

endmodule

// File: rtl/floor_indicator.sv
// Elevator floor indicator.
// The next state and the next blink phase are used to build the outputs,
// so each registered output reflects the inputs sampled on the same edge.
//   clk        : clock. All state changes on its rising edge.
//   reset      : asynchronous, active-high.
//   currentFl  : floor index. 0 is the lowest floor.
//   moving     : car in motion.
//   dirUp      : travel direction while moving. 1 = up, 0 = down.
//   HEX0       : floor low digit, or 'A' for a mezzanine. Active low.
//   HEX1       : floor digit for a mezzanine, otherwise blank. Active low.
//   HEX2       : status. Blank when idle, 'U' or 'd' while moving,
//                '-' on arrival. Active low.
//   err        : high when currentFl >= NUM_FLOORS.
module floor_indicator
  import floor_disp_pkg::*;
#(
  parameter int NUM_FLOORS = 7,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int ARRIVE_CYC = 50_000_000,
  parameter int FL_W       = $clog2(NUM_FLOORS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [FL_W-1:0] currentFl,
  input  logic            moving,
  input  logic            dirUp,
  output logic [6:0]      HEX0,
  output logic [6:0]      HEX1,
  output logic [6:0]      HEX2,
  output logic            err
);

  localparam int ACW = (ARRIVE_CYC > 1) ? $clog2(ARRIVE_CYC) : 1;
  localparam logic [ACW-1:0] ARR_LAST = ACW'(ARRIVE_CYC - 1);

  state_t         state;
  state_t         state_next;
  logic [ACW-1:0] acnt;
  logic [ACW-1:0] acnt_next;
  logic           blink_clear;
  logic           phase;
  logic           wrap;
  logic           phase_next;
  logic [3:0]     fl_ext;
  logic           fl_valid;
  logic           show;
  label_t         lbl;
  logic [6:0]     hex0_next;
  logic [6:0]     hex1_next;
  logic [6:0]     hex2_next;

  // The timer is held cleared outside MOVING. On the entry edge it starts
  // from count 0 with phase 1, so the digits are visible immediately.
  assign blink_clear = (state != MOVING);

  blink_timer #(
    .BLINK_DIV(BLINK_DIV)
  ) u_blink (
    .clk  (clk),
    .reset(reset),
    .clear(blink_clear),
    .phase(phase),
    .wrap (wrap)
  );

  // Next state and arrival counter.
  // moving=1 leaves ARRIVED before the hold timeout is checked.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (moving) state_next = MOVING;
        else        state_next = IDLE;
      end
      MOVING: begin
        if (!moving) state_next = ARRIVED;
        else         state_next = MOVING;
      end
      ARRIVED: begin
        if (moving)                state_next = MOVING;
        else if (acnt == ARR_LAST) state_next = IDLE;
        else                       state_next = ARRIVED;
      end
      default: state_next = IDLE;
    endcase

    if ((state == ARRIVED) && (state_next == ARRIVED)) begin
      acnt_next = acnt + ACW'(1);
    end else begin
      acnt_next = '0;
    end
  end

  // Output values for the state the coming edge enters.
  always_comb begin
    phase_next = blink_clear ? 1'b1 : (phase ^ wrap);
    fl_ext     = 4'(currentFl);
    fl_valid   = ({1'b0, fl_ext} < 5'(NUM_FLOORS));
    lbl        = floor_label(fl_ext);
    show       = fl_valid && ((state_next != MOVING) || phase_next);

    if (show && lbl.mezz) begin
      hex0_next = SEG_A;
      hex1_next = digit_seg(lbl.digit);
    end else if (show) begin
      hex0_next = digit_seg(lbl.digit);
      hex1_next = SEG_BLANK;
    end else begin
      hex0_next = SEG_BLANK;
      hex1_next = SEG_BLANK;
    end

    case (state_next)
      IDLE:    hex2_next = SEG_BLANK;
      MOVING:  hex2_next = dirUp ? SEG_U : SEG_D;
      ARRIVED: hex2_next = SEG_DASH;
      default: hex2_next = SEG_BLANK;
    endcase
  end

  // State, arrival counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acnt  <= '0;
      HEX0  <= SEG_BLANK;
      HEX1  <= SEG_BLANK;
      HEX2  <= SEG_BLANK;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      acnt  <= acnt_next;
      HEX0  <= hex0_next;
      HEX1  <= hex1_next;
      HEX2  <= hex2_next;
      err   <= ~fl_valid;
    end
  end

endmodule

// File: doc/floor_indicator.md
FLOOR_INDICATOR -- requirements
Module: floor_indicator

Interface
REQ-001 Parameter NUM_FLOORS, default 7, number of floor indices; legal range 2..16.
REQ-002 Parameter BLINK_DIV, default 25_000_000, clock cycles per blink half-period; legal range >= 1.
REQ-003 Parameter ARRIVE_CYC, default 50_000_000, clock cycles the arrival indication is held; legal range >= 1.
REQ-004 Derived FL_W = $clog2(NUM_FLOORS), width of the floor index.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 currentFl  input  FL_W  floor index; 0 is the lowest floor.
REQ-008 moving  input  1  car in motion.
REQ-009 dirUp  input  1  travel direction while moving: 1 = up, 0 = down.
REQ-010 HEX0, HEX1, HEX2  output  7 each  active-low seven-segment codes for the floor low digit, floor high digit and status.
REQ-011 err  output  1  currentFl >= NUM_FLOORS.

Function
REQ-012 All outputs are registered, with 1-cycle latency from the inputs to the outputs.
REQ-013 Segment codes: '1'=1111001, '2'=0100100, '3'=0110000, '4'=0011001, '5'=0010010, '6'=0000010, '7'=1111000, '8'=0000000, '9'=0010000, 'A'=0001000, 'U'=1000001, 'd'=0100001, '-'=0111111, blank=1111111.
REQ-014 Label rule: digit = ((currentFl+1)>>1)+1; currentFl even and nonzero is a mezzanine.
- Example mapping: 0 -> "1", 1 -> "2", 2 -> "2A", 3 -> "3", 4 -> "3A".
REQ-015 Non-mezzanine floor: HEX0 = digit, HEX1 = blank.
REQ-016 Mezzanine floor: HEX0 = 'A', HEX1 = digit.
REQ-017 currentFl >= NUM_FLOORS: HEX0 = HEX1 = blank and err = 1, in every state; otherwise err = 0.
REQ-018 FSM states: IDLE, MOVING, ARRIVED.
REQ-019 IDLE: steady floor digits; HEX2 = blank; moving=1 -> MOVING.
REQ-020 MOVING: HEX2 = 'U' if dirUp else 'd', evaluated every cycle; floor digits blink; moving=0 -> ARRIVED.
REQ-021 Blink behaviour:
- A phase bit toggles every BLINK_DIV cycles.
- Digits are shown when phase=1 and blank when phase=0.
- On entry to MOVING, the blink counter is cleared and phase is set to 1, so digits are visible for the first BLINK_DIV cycles.
REQ-022 ARRIVED: steady floor digits; HEX2 = '-'; an arrival counter runs from 0.
- Reaching ARRIVE_CYC-1 -> IDLE.
- moving=1 in any ARRIVED cycle -> MOVING immediately; the arrival counter is abandoned.
REQ-023 A currentFl change in any state updates the displayed label on the next cycle and does not alter state or counters.
REQ-024 Simultaneous events: moving falling on the same cycle as a blink toggle -> ARRIVED wins, and digits are steady next cycle.
REQ-025 Counters saturate nowhere: the blink counter wraps to 0 at BLINK_DIV-1, and the arrival counter is cleared on every ARRIVED entry.

Reset
REQ-026 Reset asserted (asynchronous):
- State = IDLE, counters = 0, phase = 1.
- HEX0 = HEX1 = HEX2 = blank, err = 0.
REQ-027 Reset mid-MOVING or mid-ARRIVED discards all progress.
- After release, the first edge evaluates the inputs from IDLE.

Structure
REQ-028 Package floor_disp_pkg holds:
- the segment code constants;
- the state enum (IDLE, MOVING, ARRIVED);
- function floor_label(index) returning {mezz, digit}.
REQ-029 One sub-module, blink_timer (parameter BLINK_DIV; inputs clk, reset, clear; output phase), instantiated once.

Verification
REQ-030 All directed tests use BLINK_DIV=4, ARRIVE_CYC=6, NUM_FLOORS=7.
REQ-031 Idle label sweep: sweep currentFl 0..7 with moving=0 -> one cycle later, expect:
- HEX1/HEX0 = blank/'1', blank/'2', '2'/'A', blank/'3', '3'/'A', blank/'4', '4'/'A';
- index 7: both blank with err=1.
REQ-032 Blink on move: currentFl=3, raise moving with dirUp=1 -> HEX2='U' next cycle; HEX0='3' for 4 cycles, blank for 4, '3' again.
REQ-033 Arrival timing: drop moving mid-blank phase -> next cycle HEX0='3' steady and HEX2='-' for exactly 6 cycles, then HEX2=blank (IDLE).
REQ-034 Re-move from ARRIVED: moving=1 with dirUp=0 on the 3rd ARRIVED cycle -> HEX2='d' next cycle; digits visible and blink counter restarted.
REQ-035 Asynchronous reset in MOVING: assert reset between edges -> all HEX blank immediately; after release with moving=0, IDLE display.
REQ-036 Invalid floor in MOVING: currentFl=7 -> err=1, digits blank while HEX2 keeps showing direction.
